mem_access_seq: RTL and testbench
=================================

Name: mem_access_seq

Overview:
- MEM-stage access sequencer for the LC-3b pipeline.
- Turns one decoded memory op into one or two handshaked memory transactions: LDW, LDB, STW, STB, and the two-access LDI/STI.
- Holds the pipeline stalled until the access completes.
- Its rdata output feeds the writeback 8:1 select mux directly downstream.

Parameters:
- width, 16, data and address width. Byte-lane logic requires 16.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  MEM stage holds a memory op
- req_op  input  3  0 NONE, 1 LDW, 2 LDB, 3 STW, 4 STB, 5 LDI, 6 STI, 7 reserved (treated as NONE)
- req_addr  input  width  effective address from EX/MEM
- req_wdata  input  width  store data from SR
- mem_resp  input  1  memory completes the current transaction this cycle
- mem_rdata  input  width  read data, valid with mem_resp
- mem_read  output  1  read strobe
- mem_write  output  1  write strobe
- mem_address  output  width  transaction address
- mem_wdata  output  width  write data
- mem_byte_enable  output  2  byte lane enables; bit1 = high byte
- rdata  output  width  load result for the writeback mux
- done  output  1  one-cycle pulse: op finished, rdata valid
- stall  output  1  freeze upstream pipeline registers

Behaviour:
- Async reset: state IDLE; all registered outputs 0 (mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable, rdata, done). stall = 0.
- States: IDLE, ACC1, ACC2, DONE.
- IDLE:
  - req_valid=1 and op is 1–6: latch op, addr and wdata; go to ACC1.
  - NONE/7 op: stay in IDLE, no bus activity.
- ACC1:
  - First transaction, strobe held until mem_resp.
  - LDW/LDI/STI: read at {addr[15:1],0}, byte_enable 11.
  - LDB: read at {addr[15:1],0}, byte_enable 11.
  - STW: write wdata at {addr[15:1],0}, byte_enable 11.
  - STB: write {wdata[7:0],wdata[7:0]}; byte_enable 10 if addr[0]=1, else 01.
  - On mem_resp:
    - LDW: latch rdata = mem_rdata.
    - LDB: latch rdata = sign-extend of mem_rdata[15:8] if addr[0]=1, else mem_rdata[7:0].
    - Loads and stores: go to DONE.
    - LDI/STI: latch pointer = mem_rdata; go to ACC2.
- ACC2:
  - LDI: read at {ptr[15:1],0}; STI: write wdata at {ptr[15:1],0}, byte_enable 11.
  - On mem_resp: LDI latches rdata; go to DONE.
- DONE:
  - done=1 for exactly one cycle, strobes low, then IDLE.
  - A new request is sampled only in IDLE, so back-to-back ops have a minimum 1-cycle IDLE gap.
- Strobes are registered. mem_read and mem_write are never high together, and stay high continuously until mem_resp. mem_address and mem_wdata are stable while a strobe is high.
- mem_resp outside ACC1/ACC2 is ignored.
- stall (combinational) = (state != DONE) && ((state != IDLE) || (req_valid && op in 1..6)). This deasserts in the cycle done pulses, so the pipeline advances exactly once per op.
- Stores leave rdata unchanged.
- Zero-wait memory (mem_resp in the first strobe cycle): LDW/STW take 3 cycles IDLE→DONE; LDI/STI take 4.
- Reset mid-transaction: abort immediately to IDLE; strobes drop asynchronously; no done pulse.

Optional Feature:
- Macro MEM_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles (16 bits): count of cycles with stall=1.
  - Saturates at 16'hFFFF; cleared by rst.
  - Adds input stall_cnt_clr (1 bit): synchronous clear, which wins over increment.
- Undefined: neither port exists; no counter logic.

Test Plan:
- LDW, addr 16'h3001, memory returns 16'hBEEF after 2 wait cycles → mem_address 16'h3000, byte_enable 11; rdata 16'hBEEF; done one pulse; stall high until the done cycle.
- LDB, addr 16'h2005, mem_rdata 16'h80AB → rdata 16'hFF80. LDB, addr 16'h2004 → rdata 16'hFFAB.
- STB, addr 16'h1001, wdata 16'h1234 → mem_write, mem_wdata 16'h3434, byte_enable 10; rdata unchanged; done after resp.
- LDI, addr 16'h4000, first resp 16'h5002, second resp 16'h0042 → second read at 16'h5002; rdata 16'h0042; exactly two transactions.
- STI mid-ACC2 with rst asserted → strobes 0 the same cycle; state IDLE; done never pulses; next LDW completes normally.
- MEM_STALL_CNT_EN: LDW with 3 wait cycles → stall_cycles 5 (accept + 4 ACC1 cycles); stall_cnt_clr → 0 next cycle.

Source files
------------

// File: rtl/mem_access_seq.sv
// mem_access_seq: LC-3b MEM-stage sequencer turning one memory op into one or two handshaked bus transactions.
// Optional stall-cycle counter is enabled by defining MEM_STALL_CNT_EN.
module mem_access_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MEM_STALL_CNT_EN
    input  logic             stall_cnt_clr,
    output logic [15:0]      stall_cycles,
`endif
    input  logic             req_valid,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic             mem_resp,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_read,
    output logic             mem_write,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [1:0]       mem_byte_enable,
    output logic [WIDTH-1:0] rdata,
    output logic             done,
    output logic             stall
);
    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    localparam logic [2:0] OP_LDW = 3'd1;
    localparam logic [2:0] OP_LDB = 3'd2;
    localparam logic [2:0] OP_STW = 3'd3;
    localparam logic [2:0] OP_STB = 3'd4;
    localparam logic [2:0] OP_LDI = 3'd5;
    localparam logic [2:0] OP_STI = 3'd6;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             addr_lsb_q, addr_lsb_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic [WIDTH-1:0] address_q, address_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]       be_q, be_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             done_q, done_d;
    logic             op_ok;
    logic             req_is_read;
    logic [7:0]       byte_sel;
    logic [WIDTH-1:0] byte_ext;

    assign op_ok       = (req_op != 3'd0) && (req_op != 3'd7);
    assign req_is_read = (req_op == OP_LDW) || (req_op == OP_LDB) || (req_op == OP_LDI) || (req_op == OP_STI);
    assign byte_sel    = addr_lsb_q ? mem_rdata[15:8] : mem_rdata[7:0];
    assign byte_ext    = {{(WIDTH-8){byte_sel[7]}}, byte_sel};

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_lsb_d  = addr_lsb_q;
        wdata_d     = wdata_q;
        read_d      = read_q;
        write_d     = write_q;
        address_d   = address_q;
        mem_wdata_d = mem_wdata_q;
        be_d        = be_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && op_ok) begin
                    state_d     = ACC1;
                    op_d        = req_op;
                    addr_lsb_d  = req_addr[0];
                    wdata_d     = req_wdata;
                    read_d      = req_is_read;
                    write_d     = !req_is_read;
                    address_d   = {req_addr[WIDTH-1:1], 1'b0};
                    mem_wdata_d = (req_op == OP_STB) ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata;
                    be_d        = (req_op == OP_STB) ? (req_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                end
            end
            ACC1: begin
                if (mem_resp) begin
                    if ((op_q == OP_LDI) || (op_q == OP_STI)) begin
                        // Indirect: the first response is the pointer; the strobe stays up into the second access.
                        state_d     = ACC2;
                        read_d      = (op_q == OP_LDI);
                        write_d     = (op_q == OP_STI);
                        address_d   = {mem_rdata[WIDTH-1:1], 1'b0};
                        mem_wdata_d = wdata_q;
                        be_d        = 2'b11;
                    end else begin
                        state_d = DONE;
                        read_d  = 1'b0;
                        write_d = 1'b0;
                        done_d  = 1'b1;
                        rdata_d = (op_q == OP_LDW) ? mem_rdata : (op_q == OP_LDB) ? byte_ext : rdata_q;
                    end
                end
            end
            ACC2: begin
                if (mem_resp) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    done_d  = 1'b1;
                    rdata_d = (op_q == OP_LDI) ? mem_rdata : rdata_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            addr_lsb_q  <= 1'b0;
            wdata_q     <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= '0;
            mem_wdata_q <= '0;
            be_q        <= 2'b00;
            rdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_lsb_q  <= addr_lsb_d;
            wdata_q     <= wdata_d;
            read_q      <= read_d;
            write_q     <= write_d;
            address_q   <= address_d;
            mem_wdata_q <= mem_wdata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
        end
    end

    assign mem_read        = read_q;
    assign mem_write       = write_q;
    assign mem_address     = address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = be_q;
    assign rdata           = rdata_q;
    assign done            = done_q;
    assign stall           = (state_q != DONE) && ((state_q != IDLE) || (req_valid && op_ok));

`ifdef MEM_STALL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = stall_cnt_clr ? 16'd0 : (stall && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end

    assign stall_cycles = cnt_q;
`endif
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: table-driven directed checks of mem_access_seq with a cycle-accurate memory responder.
module tb_mem_access_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        mem_resp = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_read, mem_write, done, stall;
    logic [15:0] mem_address, mem_wdata, rdata;
    logic [1:0]  mem_byte_enable;
`ifdef MEM_STALL_CNT_EN
    logic        stall_cnt_clr = 1'b0;
    logic [15:0] stall_cycles;
`endif
    int total = 0;
    int passed = 0;

    mem_access_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
`ifdef MEM_STALL_CNT_EN
        .stall_cnt_clr(stall_cnt_clr), .stall_cycles(stall_cycles),
`endif
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .rdata(rdata), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] r1;
        logic [15:0] r2;
        int          waits;
        logic [15:0] a1;
        logic [1:0]  be1;
        logic [15:0] wd1;
        logic [15:0] a2;
        logic [15:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        logic first_wr;
        logic is_wr;
        n = (v.op == 3'd5 || v.op == 3'd6) ? 2 : (v.op >= 3'd1 && v.op <= 3'd4) ? 1 : 0;
        first_wr = (v.op == 3'd3) || (v.op == 3'd4);
        @(negedge clk);
        req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        #1 chk("stall_on_req", {15'd0, stall}, {15'd0, n != 0});
        @(negedge clk);
        req_valid = 1'b0; req_op = 3'd0;
        for (int t = 0; t < n; t++) begin
            is_wr = (t == 0) ? first_wr : (v.op == 3'd6);
            chk("address", mem_address, (t == 0) ? v.a1 : v.a2);
            chk("byte_enable", {14'd0, mem_byte_enable}, {14'd0, (t == 0) ? v.be1 : 2'b11});
            chk("strobes", {14'd0, mem_read, mem_write}, {14'd0, !is_wr, is_wr});
            if (is_wr) chk("wdata", mem_wdata, (t == 0) ? v.wd1 : v.wdata);
            for (int w = 0; w < v.waits; w++) begin
                @(negedge clk);
                chk("strobe_held", {14'd0, mem_read, mem_write}, {14'd0, !is_wr, is_wr});
                chk("stall_held", {15'd0, stall}, 16'd1);
            end
            mem_resp = 1'b1;
            mem_rdata = (t == 0) ? v.r1 : v.r2;
            @(negedge clk);
            mem_resp = 1'b0;
            mem_rdata = 16'hDEAD;
        end
        if (n > 0) begin
            chk("done_pulse", {15'd0, done}, 16'd1);
            chk("stall_done", {15'd0, stall}, 16'd0);
            chk("strobes_done", {14'd0, mem_read, mem_write}, 16'd0);
            chk("rdata", rdata, v.exp_rdata);
            @(negedge clk);
            chk("done_drop", {15'd0, done}, 16'd0);
        end else begin
            chk("noop_done", {15'd0, done}, 16'd0);
            chk("noop_strobes", {14'd0, mem_read, mem_write}, 16'd0);
            chk("noop_rdata", rdata, v.exp_rdata);
        end
    endtask

    vec_t vecs[12];
    vec_t v;
    logic saw_done;

    initial begin
        //            op    addr      wdata     r1        r2        w  a1        be     wd1       a2        rdata
        vecs[0]  = '{3'd1, 16'h3001, 16'h0000, 16'hBEEF, 16'h0000, 2, 16'h3000, 2'b11, 16'h0000, 16'h0000, 16'hBEEF};
        vecs[1]  = '{3'd2, 16'h2005, 16'h0000, 16'h80AB, 16'h0000, 0, 16'h2004, 2'b11, 16'h0000, 16'h0000, 16'hFF80};
        vecs[2]  = '{3'd2, 16'h2004, 16'h0000, 16'h80AB, 16'h0000, 1, 16'h2004, 2'b11, 16'h0000, 16'h0000, 16'hFFAB};
        vecs[3]  = '{3'd4, 16'h1001, 16'h1234, 16'h0000, 16'h0000, 0, 16'h1000, 2'b10, 16'h3434, 16'h0000, 16'hFFAB};
        vecs[4]  = '{3'd4, 16'h1000, 16'h00C5, 16'h0000, 16'h0000, 1, 16'h1000, 2'b01, 16'hC5C5, 16'h0000, 16'hFFAB};
        vecs[5]  = '{3'd3, 16'h0FFF, 16'hA5A5, 16'h0000, 16'h0000, 0, 16'h0FFE, 2'b11, 16'hA5A5, 16'h0000, 16'hFFAB};
        vecs[6]  = '{3'd5, 16'h4000, 16'h0000, 16'h5002, 16'h0042, 0, 16'h4000, 2'b11, 16'h0000, 16'h5002, 16'h0042};
        vecs[7]  = '{3'd6, 16'h6001, 16'h7777, 16'h1235, 16'h0000, 1, 16'h6000, 2'b11, 16'h0000, 16'h1234, 16'h0042};
        vecs[8]  = '{3'd2, 16'h2007, 16'h0000, 16'h7F00, 16'h0000, 0, 16'h2006, 2'b11, 16'h0000, 16'h0000, 16'h007F};
        vecs[9]  = '{3'd0, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 0, 16'h0000, 2'b11, 16'h0000, 16'h0000, 16'h007F};
        vecs[10] = '{3'd7, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 0, 16'h0000, 2'b11, 16'h0000, 16'h0000, 16'h007F};
        vecs[11] = '{3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 2'b11, 16'h0000, 16'h0000, 16'h0000};

        #2;
        chk("reset_strobes", {14'd0, mem_read, mem_write}, 16'd0);
        chk("reset_addr", mem_address, 16'h0000);
        chk("reset_wdata", mem_wdata, 16'h0000);
        chk("reset_be", {14'd0, mem_byte_enable}, 16'd0);
        chk("reset_rdata", rdata, 16'h0000);
        chk("reset_done_stall", {14'd0, done, stall}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // A response while idle must not disturb anything.
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 16'hFFFF;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("idle_resp_done", {15'd0, done}, 16'd0);
        chk("idle_resp_rdata", rdata, 16'h0000);
        chk("idle_resp_strobes", {14'd0, mem_read, mem_write}, 16'd0);

        // STI aborted by reset during its second access.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd6; req_addr = 16'h6000; req_wdata = 16'h1111;
        @(negedge clk);
        req_valid = 1'b0; req_op = 3'd0;
        mem_resp = 1'b1; mem_rdata = 16'h2222;
        @(negedge clk);
        mem_resp = 1'b0;
        chk("sti_acc2_write", {14'd0, mem_read, mem_write}, 16'd1);
        chk("sti_acc2_addr", mem_address, 16'h2222);
        #1 rst = 1'b1;
        #1;
        chk("abort_strobes", {14'd0, mem_read, mem_write}, 16'd0);
        chk("abort_stall", {15'd0, stall}, 16'd0);
        saw_done = done;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        chk("abort_no_done", {15'd0, saw_done}, 16'd0);
        v = '{3'd1, 16'h3001, 16'h0000, 16'h1357, 16'h0000, 0, 16'h3000, 2'b11, 16'h0000, 16'h0000, 16'h1357};
        run_vec(v);

`ifdef MEM_STALL_CNT_EN
        @(negedge clk);
        stall_cnt_clr = 1'b1;
        @(negedge clk);
        stall_cnt_clr = 1'b0;
        chk("cnt_cleared", stall_cycles, 16'd0);
        v = '{3'd1, 16'h2000, 16'h0000, 16'h2468, 16'h0000, 3, 16'h2000, 2'b11, 16'h0000, 16'h0000, 16'h2468};
        run_vec(v);
        chk("stall_cycles", stall_cycles, 16'd5);
        @(negedge clk);
        stall_cnt_clr = 1'b1;
        @(negedge clk);
        stall_cnt_clr = 1'b0;
        chk("cnt_clr", stall_cycles, 16'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
